// File: rtl/stream_demultiplexer_pkg.sv
// Shared types and index mapping for the stream mux/demux pair.
// The mapping macro is the single source for select-to-output order.
package stream_demultiplexer_pkg;

  typedef enum logic [1:0] {
    ROUTE_UNI,
    ROUTE_BCAST,
    ROUTE_DROP
  } route_e;

  function automatic int unsigned map_index(
    input bit          asc,
    input int unsigned n,
    input int unsigned s
  );
    return asc ? (n - 1 - s) : s;
  endfunction

endpackage

`ifndef STREAM_MAP_INDEX
`define STREAM_MAP_INDEX(asc, n, s) \
  stream_demultiplexer_pkg::map_index(asc, n, s)
`endif

// File: rtl/stream_slot.sv
// One-entry output register stage.
// A drained entry may be refilled in the same cycle.
module stream_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    unique case (1'b1)
      load_i: begin
        valid_d = 1'b1;
        data_d  = load_data_i;
      end
      (!load_i && ready_i): begin
        valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/stream_demultiplexer.sv
// One-to-many stream distributor with unicast, broadcast and
// drop of out-of-range selects; one register stage per output.
module stream_demultiplexer
  import stream_demultiplexer_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int NUM_OUTPUTS     = 2,
  parameter bit ASCENDING_INDEX = 1'b0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  input  logic [$clog2(NUM_OUTPUTS)-1:0] in_select,
  input  logic                           in_broadcast,
  output logic [NUM_OUTPUTS-1:0]         out_valid,
  input  logic [NUM_OUTPUTS-1:0]         out_ready,
  output logic [WIDTH*NUM_OUTPUTS-1:0]   out_data,
  output logic                           select_error
);

  localparam int unsigned NOUT = NUM_OUTPUTS;

  logic [NUM_OUTPUTS-1:0] slot_free;
  logic [NUM_OUTPUTS-1:0] hit;
  logic [NUM_OUTPUTS-1:0] load;
  int unsigned            tgt;
  logic                   in_range;
  route_e                 route;
  logic                   accept;
  logic                   err_d, err_q;

  always_comb begin
    in_range = (32'(in_select) < NOUT);
    tgt      = `STREAM_MAP_INDEX(ASCENDING_INDEX, NOUT,
                                 32'(in_select));
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      slot_free[i] = !out_valid[i] || out_ready[i];
      hit[i]       = in_range && (tgt == unsigned'(i));
    end
  end

  always_comb begin
    route = ROUTE_UNI;
    unique case (1'b1)
      in_broadcast:                route = ROUTE_BCAST;
      (!in_broadcast && !in_range): route = ROUTE_DROP;
      (!in_broadcast && in_range):  route = ROUTE_UNI;
      default: ;
    endcase
  end

  // Ready never looks at in_valid, only at slot occupancy.
  always_comb begin
    in_ready = 1'b0;
    unique case (route)
      ROUTE_BCAST: in_ready = &slot_free;
      ROUTE_DROP:  in_ready = 1'b1;
      ROUTE_UNI:   in_ready = |(slot_free & hit);
      default:     in_ready = 1'b0;
    endcase
  end

  always_comb begin
    accept = in_valid && in_ready;
    load   = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      load[i] = accept &&
                ((route == ROUTE_BCAST) ||
                 ((route == ROUTE_UNI) && hit[i]));
    end
    err_d = accept && (route == ROUTE_DROP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign select_error = err_q;

  for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_slot
    stream_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_i     (load[g]),
      .load_data_i(in_data),
      .valid_o    (out_valid[g]),
      .ready_i    (out_ready[g]),
      .data_o     (out_data[g*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_stream_demultiplexer.sv
// Self-checking bench: directed scenarios plus randomized traffic
// compared against a slot-level behavioural model.
module tb_stream_demultiplexer;

  logic        clk;
  logic        reset_n;

  logic        iv, ir, ib, serr;
  logic [31:0] id;
  logic [1:0]  isel;
  logic [2:0]  ov, ordy;
  logic [95:0] od;

  logic         a_iv, a_ir, a_ib, a_serr;
  logic [31:0]  a_id;
  logic [1:0]   a_isel;
  logic [3:0]   a_ov, a_ordy;
  logic [127:0] a_od;

  int passed;
  int total;

  bit          mv[3];
  logic [31:0] md[3];
  bit          merr;

  stream_demultiplexer #(
    .WIDTH(32), .NUM_OUTPUTS(3), .ASCENDING_INDEX(1'b0)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(iv), .in_ready(ir), .in_data(id),
    .in_select(isel), .in_broadcast(ib),
    .out_valid(ov), .out_ready(ordy), .out_data(od),
    .select_error(serr)
  );

  stream_demultiplexer #(
    .WIDTH(32), .NUM_OUTPUTS(4), .ASCENDING_INDEX(1'b1)
  ) dut_a (
    .clk(clk), .reset_n(reset_n),
    .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .in_select(a_isel), .in_broadcast(a_ib),
    .out_valid(a_ov), .out_ready(a_ordy), .out_data(a_od),
    .select_error(a_serr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
    end
    merr = 1'b0;
  endtask

  // Called right after a falling edge; returns after the next one.
  task automatic cycle(input bit v, input logic [31:0] d,
                       input logic [1:0] s, input bit b,
                       input logic [2:0] r);
    bit          free[3];
    bit          er, acc, allf;
    logic [2:0]  ev;
    logic [95:0] ed;
    iv = v; id = d; isel = s; ib = b; ordy = r;
    #1;
    allf = 1'b1;
    for (int i = 0; i < 3; i++) begin
      free[i] = !mv[i] || r[i];
      allf    = allf && free[i];
    end
    if (b)           er = allf;
    else if (s >= 3) er = 1'b1;
    else             er = free[s];
    total++;
    if (ir !== er)
      $display("FAIL in_ready: got %b want %b (sel=%0d bc=%b)",
               ir, er, s, b);
    else passed++;
    @(posedge clk);
    acc = v && er;
    for (int i = 0; i < 3; i++) begin
      if (acc && (b || (s == i))) begin
        mv[i] = 1'b1;
        md[i] = d;
      end else if (r[i]) begin
        mv[i] = 1'b0;
      end
    end
    merr = acc && !b && (s >= 3);
    #1;
    ev = {mv[2], mv[1], mv[0]};
    ed = {md[2], md[1], md[0]};
    total++;
    if (ov !== ev)
      $display("FAIL out_valid: got %b want %b", ov, ev);
    else passed++;
    total++;
    if (od !== ed)
      $display("FAIL out_data: got %h want %h", od, ed);
    else passed++;
    total++;
    if (serr !== merr)
      $display("FAIL select_error: got %b want %b", serr, merr);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    iv = 0; id = '0; isel = '0; ib = 0; ordy = '1;
    a_iv = 0; a_id = '0; a_isel = '0; a_ib = 0; a_ordy = '1;
    model_clear();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    cycle(1, 32'hDEAD_0001, 2'd0, 1, 3'b000);
    cycle(0, 32'h0, 2'd0, 0, 3'b000);
    #3;
    reset_n = 1'b0;
    model_clear();
    #1;
    total++;
    if (ov !== 3'b000)
      $display("FAIL reset out_valid: got %b want 000", ov);
    else passed++;
    total++;
    if (od !== 96'h0)
      $display("FAIL reset out_data: got %h want 0", od);
    else passed++;
    total++;
    if (serr !== 1'b0)
      $display("FAIL reset select_error: got %b want 0", serr);
    else passed++;
    isel = 2'd1; ib = 1'b0;
    #1;
    total++;
    if (ir !== 1'b1)
      $display("FAIL reset in_ready: got %b want 1", ir);
    else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unicast();
    cycle(1, 32'hA5A5_0001, 2'd2, 0, 3'b000);
    total++;
    if (ov !== 3'b100 || od[95:64] !== 32'hA5A5_0001)
      $display("FAIL unicast: got v=%b d=%h want v=100 d=a5a50001",
               ov, od[95:64]);
    else passed++;
    cycle(0, 32'h0, 2'd0, 0, 3'b111);
  endtask

  task automatic test_backpressure();
    cycle(1, 32'h0000_0B01, 2'd0, 0, 3'b000);
    cycle(1, 32'h0000_0B02, 2'd0, 0, 3'b000);
    cycle(1, 32'h0000_0B02, 2'd0, 0, 3'b000);
    total++;
    if (od[31:0] !== 32'h0000_0B01)
      $display("FAIL bp hold: got %h want 00000b01", od[31:0]);
    else passed++;
    cycle(1, 32'h0000_0C01, 2'd1, 0, 3'b010);
    cycle(1, 32'h0000_0C02, 2'd1, 0, 3'b010);
    cycle(1, 32'h0000_0B02, 2'd0, 0, 3'b001);
    total++;
    if (ov[0] !== 1'b1 || od[31:0] !== 32'h0000_0B02)
      $display("FAIL bp refill: got v=%b d=%h want v=1 d=00000b02",
               ov[0], od[31:0]);
    else passed++;
    cycle(0, 32'h0, 2'd0, 0, 3'b111);
  endtask

  task automatic test_broadcast();
    cycle(1, 32'h0000_0D01, 2'd1, 0, 3'b000);
    cycle(1, 32'h1234_5678, 2'd0, 1, 3'b101);
    cycle(1, 32'h1234_5678, 2'd0, 1, 3'b101);
    cycle(1, 32'h1234_5678, 2'd0, 1, 3'b111);
    total++;
    if (ov !== 3'b111 || od !== {3{32'h1234_5678}})
      $display("FAIL broadcast: got v=%b d=%h want v=111 d=%h",
               ov, od, {3{32'h1234_5678}});
    else passed++;
    cycle(0, 32'h0, 2'd0, 0, 3'b111);
  endtask

  task automatic test_out_of_range();
    cycle(1, 32'h0000_0E01, 2'd1, 0, 3'b000);
    cycle(1, 32'hBAD0_0003, 2'd3, 0, 3'b000);
    total++;
    if (serr !== 1'b1 || ov !== 3'b010)
      $display("FAIL oor pulse: got err=%b v=%b want err=1 v=010",
               serr, ov);
    else passed++;
    cycle(0, 32'h0, 2'd0, 0, 3'b000);
    total++;
    if (serr !== 1'b0)
      $display("FAIL oor one-cycle: got err=%b want 0", serr);
    else passed++;
    cycle(0, 32'h0, 2'd0, 0, 3'b111);
  endtask

  task automatic test_ascending();
    a_iv = 1; a_id = 32'hA5C0_0000; a_isel = 2'd0;
    a_ib = 0; a_ordy = 4'b0000;
    #1;
    total++;
    if (a_ir !== 1'b1)
      $display("FAIL asc ready: got %b want 1", a_ir);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (a_ov !== 4'b1000 || a_od[127:96] !== 32'hA5C0_0000)
      $display("FAIL asc sel0: got v=%b d=%h want v=1000 d=a5c00000",
               a_ov, a_od[127:96]);
    else passed++;
    @(negedge clk);
    a_id = 32'hA5C0_0003; a_isel = 2'd3;
    @(posedge clk); #1;
    total++;
    if (a_ov !== 4'b1001 || a_od[31:0] !== 32'hA5C0_0003)
      $display("FAIL asc sel3: got v=%b d=%h want v=1001 d=a5c00003",
               a_ov, a_od[31:0]);
    else passed++;
    @(negedge clk);
    a_iv = 0; a_ordy = 4'b1111;
    @(posedge clk); #1;
    total++;
    if (a_ov !== 4'b0000)
      $display("FAIL asc drain: got v=%b want 0000", a_ov);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_random();
    bit          v, b;
    logic [1:0]  s;
    logic [2:0]  r;
    logic [31:0] d;
    for (int n = 0; n < 400; n++) begin
      v = ($urandom_range(3, 0) != 0);
      b = ($urandom_range(7, 0) == 0);
      s = 2'($urandom_range(3, 0));
      r = 3'($urandom_range(7, 0));
      d = $urandom;
      cycle(v, d, s, b, r);
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_unicast();
    test_backpressure();
    test_broadcast();
    test_out_of_range();
    test_ascending();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
